// File: rtl/ws2812_frame_driver.sv
// ws2812_frame_driver: double-buffered WS2812 strip driver with global brightness scaling
// and start/busy/done handshake.
module ws2812_frame_driver #(
  parameter int NUM_LEDS     = 64,
  parameter int SYS_FREQ_MHZ = 100,
  parameter int BIT_NS       = 1250,
  parameter int T0H_NS       = 400,
  parameter int T1H_NS       = 800,
  parameter int RESET_US     = 80,
  parameter int ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic [7:0]        brightness,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              out
);
  localparam int BIT_CYC = BIT_NS * SYS_FREQ_MHZ / 1000;
  localparam int T0H_CYC = T0H_NS * SYS_FREQ_MHZ / 1000;
  localparam int T1H_CYC = T1H_NS * SYS_FREQ_MHZ / 1000;
  localparam int RST_CYC = RESET_US * SYS_FREQ_MHZ;
  localparam int CW      = $clog2((RST_CYC > BIT_CYC) ? RST_CYC : BIT_CYC) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

  state_t            state;
  logic              sel;
  logic [7:0]        bri_q;
  logic [23:0]       shreg;
  logic [4:0]        bit_idx;
  logic [ADDR_W-1:0] led_idx;
  logic [CW-1:0]     cnt;
  logic [23:0]       mem [2][NUM_LEDS];
  logic [23:0]       px;
  logic [CW-1:0]     hi_end;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * 16'({1'b0, b} + 9'd1);
    return p[15:8];
  endfunction

  // mem[sel] is the back buffer; a write on the start edge uses the old sel,
  // so it lands in the buffer that becomes front
  always_ff @(posedge clk)
    if (wr_en && int'(wr_addr) < NUM_LEDS) mem[sel][wr_addr] <= wr_data;

  assign px     = mem[~sel][led_idx];
  assign hi_end = shreg[23] ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      bri_q      <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      led_idx    <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      out        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (frame_start) begin
          sel     <= ~sel;
          bri_q   <= brightness;
          busy    <= 1'b1;
          led_idx <= '0;
          bit_idx <= '0;
          state   <= LOAD;
        end
        LOAD: begin
          shreg <= {scale(px[23:16], bri_q), scale(px[15:8], bri_q), scale(px[7:0], bri_q)};
          cnt   <= '0;
          out   <= 1'b1;
          state <= HIGH;
        end
        HIGH: begin
          cnt <= cnt + 1'b1;
          if (cnt == hi_end) begin
            out   <= 1'b0;
            state <= LOW;
          end
        end
        LOW: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BIT_CYC - 1)) begin
            cnt     <= '0;
            shreg   <= shreg << 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx != 5'd23) begin
              out   <= 1'b1;
              state <= HIGH;
            end else begin
              bit_idx <= '0;
              if (led_idx == ADDR_W'(NUM_LEDS - 1)) state <= LATCH;
              else begin
                led_idx <= led_idx + 1'b1;
                state   <= LOAD;
              end
            end
          end
        end
        LATCH: begin
          cnt        <= cnt + 1'b1;
          frame_done <= (cnt == CW'(RST_CYC - 2));
          if (cnt == CW'(RST_CYC - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
